// File: rtl/zjh_vote_pkg.sv
// Shared definitions for the judge-vote controller: state encodings,
// default timing parameters and a 3-bit popcount helper.
package zjh_vote_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_VOTE   = 2'd1,
        ST_RESULT = 2'd2
    } state_t;

    localparam int DEF_WIN_CYC  = 16;
    localparam int DEF_HOLD_CYC = 4;
    localparam int DEF_TW       = 5;

    function automatic logic [1:0] popcount3(input logic [2:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
    endfunction

endpackage

// File: rtl/zjh_vote_if.sv
// Control/status bundle of the vote controller; master drives the round
// controls and judge buttons, slave is the controller.
interface zjh_vote_if #(
    parameter int TW = 5
);
    logic          start;
    logic          abort;
    logic [2:0]    vote;
    logic          busy;
    logic [1:0]    state;
    logic [2:0]    latched;
    logic [1:0]    count;
    logic [TW-1:0] timer;
    logic          done;
    logic          pass;

    modport master (
        output start, abort, vote,
        input  busy, state, latched, count, timer, done, pass
    );

    modport slave (
        input  start, abort, vote,
        output busy, state, latched, count, timer, done, pass
    );
endinterface

// File: rtl/zjh_jtd.sv
// Three-input majority voter: high when at least two judges agree.
module zjh_jtd (
    input  logic [2:0] v,
    output logic       maj
);
    assign maj = (v[2] & v[1]) | (v[2] & v[0]) | (v[1] & v[0]);
endmodule

// File: rtl/zjh_vote_ctrl.sv
// Voting-round controller: opens a timed window, captures sticky judge votes,
// closes early on a full house, and holds the majority verdict for a while.
//   state   | meaning
//   IDLE    | waiting for start; verdict cleared, last capture kept
//   VOTE    | window open, votes accumulate, timer counts down
//   RESULT  | verdict valid and held, timer counts down
module zjh_vote_ctrl
    import zjh_vote_pkg::*;
#(
    parameter int WIN_CYC  = DEF_WIN_CYC,
    parameter int HOLD_CYC = DEF_HOLD_CYC,
    parameter int TW       = DEF_TW
) (
    input  logic         clk,
    input  logic         rst_n,
    zjh_vote_if.slave    bus
);

    localparam logic [TW-1:0] WIN_LOAD  = TW'(WIN_CYC - 1);
    localparam logic [TW-1:0] HOLD_LOAD = TW'(HOLD_CYC - 1);
    localparam logic [TW-1:0] ONE       = TW'(1);

    state_t        state_q, state_n;
    logic [2:0]    latched_q, latched_n;
    logic [TW-1:0] timer_q, timer_n;
    logic          done_q, done_n;
    logic          pass_q, pass_n;

    logic [2:0]    acc;
    logic          maj;

    // Votes present in the closing cycle must count, so the voter sees the
    // live buttons merged with the capture, not just the register.
    assign acc = latched_q | bus.vote;

    zjh_jtd u_jtd (
        .v   (acc),
        .maj (maj)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            latched_q <= '0;
            timer_q   <= '0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
        end else begin
            state_q   <= state_n;
            latched_q <= latched_n;
            timer_q   <= timer_n;
            done_q    <= done_n;
            pass_q    <= pass_n;
        end
    end

    always_comb begin
        state_n   = state_q;
        latched_n = latched_q;
        timer_n   = timer_q;
        done_n    = 1'b0;
        pass_n    = pass_q;
        case (state_q)
            ST_IDLE: begin
                pass_n = 1'b0;
                if (bus.start && !bus.abort) begin
                    state_n   = ST_VOTE;
                    latched_n = '0;
                    timer_n   = WIN_LOAD;
                end
            end
            ST_VOTE: begin
                if (bus.abort) begin
                    state_n   = ST_IDLE;
                    latched_n = '0;
                    timer_n   = '0;
                    pass_n    = 1'b0;
                end else if (timer_q == '0 || acc == 3'b111) begin
                    state_n   = ST_RESULT;
                    latched_n = acc;
                    pass_n    = maj;
                    done_n    = 1'b1;
                    timer_n   = HOLD_LOAD;
                end else begin
                    latched_n = acc;
                    timer_n   = timer_q - ONE;
                end
            end
            ST_RESULT: begin
                if (bus.abort) begin
                    state_n   = ST_IDLE;
                    latched_n = '0;
                    timer_n   = '0;
                    pass_n    = 1'b0;
                end else if (timer_q == '0) begin
                    state_n = ST_IDLE;
                    pass_n  = 1'b0;
                end else begin
                    timer_n = timer_q - ONE;
                end
            end
            default: begin
                state_n   = ST_IDLE;
                latched_n = '0;
                timer_n   = '0;
                pass_n    = 1'b0;
            end
        endcase
    end

    assign bus.busy    = (state_q == ST_VOTE) || (state_q == ST_RESULT);
    assign bus.state   = state_q;
    assign bus.latched = latched_q;
    assign bus.count   = popcount3(latched_q);
    assign bus.timer   = timer_q;
    assign bus.done    = done_q;
    assign bus.pass    = pass_q;

endmodule
